// File: rtl/wb_stage_p.sv
// Writeback stage: MEM/WB pipeline register with stall/flush, sub-word load
// extraction, r0 write suppression, debug tag forwarding and a retire counter.
module wb_stage_p #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int TAG_W  = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic              mem_stall,
    input  logic              mem_flush,
    input  logic [REG_AW-1:0] mem_destR,
    input  logic [DATA_W-1:0] mem_aluR,
    input  logic [DATA_W-1:0] mem_mdata,
    input  logic              mem_wreg,
    input  logic              mem_m2reg,
    input  logic [1:0]        mem_ld_size,
    input  logic              mem_ld_uns,
    input  logic [TAG_W-1:0]  MEM_ins_type,
    input  logic [TAG_W-1:0]  MEM_ins_number,
    output logic              wb_valid,
    output logic              wb_wreg,
    output logic [REG_AW-1:0] wb_destR,
    output logic [DATA_W-1:0] wb_dest,
    output logic [TAG_W-1:0]  WB_ins_type,
    output logic [TAG_W-1:0]  WB_ins_number,
    output logic [CNT_W-1:0]  wb_retire_cnt
);

    localparam int LB = $clog2(DATA_W / 8);

    logic              valid_q,   valid_d;
    logic              wreg_q,    wreg_d;
    logic              m2reg_q,   m2reg_d;
    logic [REG_AW-1:0] destR_q,   destR_d;
    logic [DATA_W-1:0] aluR_q,    aluR_d;
    logic [DATA_W-1:0] mdata_q,   mdata_d;
    logic [1:0]        ld_size_q, ld_size_d;
    logic              ld_uns_q,  ld_uns_d;
    logic [TAG_W-1:0]  type_q,    type_d;
    logic [TAG_W-1:0]  number_q,  number_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;

    // Flush clears every pipeline field but leaves the retire count alone.
    always_comb begin
        valid_d   = valid_q;
        wreg_d    = wreg_q;
        m2reg_d   = m2reg_q;
        destR_d   = destR_q;
        aluR_d    = aluR_q;
        mdata_d   = mdata_q;
        ld_size_d = ld_size_q;
        ld_uns_d  = ld_uns_q;
        type_d    = type_q;
        number_d  = number_q;
        cnt_d     = cnt_q;
        if (mem_flush) begin
            valid_d   = 1'b0;
            wreg_d    = 1'b0;
            m2reg_d   = 1'b0;
            destR_d   = '0;
            aluR_d    = '0;
            mdata_d   = '0;
            ld_size_d = '0;
            ld_uns_d  = 1'b0;
            type_d    = '0;
            number_d  = '0;
        end else if (!mem_stall) begin
            valid_d   = mem_valid;
            wreg_d    = mem_wreg;
            m2reg_d   = mem_m2reg;
            destR_d   = mem_destR;
            aluR_d    = mem_aluR;
            mdata_d   = mem_mdata;
            ld_size_d = mem_ld_size;
            ld_uns_d  = mem_ld_uns;
            type_d    = MEM_ins_type;
            number_d  = MEM_ins_number;
            if (mem_valid) begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            wreg_q    <= 1'b0;
            m2reg_q   <= 1'b0;
            destR_q   <= '0;
            aluR_q    <= '0;
            mdata_q   <= '0;
            ld_size_q <= '0;
            ld_uns_q  <= 1'b0;
            type_q    <= '0;
            number_q  <= '0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            wreg_q    <= wreg_d;
            m2reg_q   <= m2reg_d;
            destR_q   <= destR_d;
            aluR_q    <= aluR_d;
            mdata_q   <= mdata_d;
            ld_size_q <= ld_size_d;
            ld_uns_q  <= ld_uns_d;
            type_q    <= type_d;
            number_q  <= number_d;
            cnt_q     <= cnt_d;
        end
    end

    logic [LB-1:0]     lane_a;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [DATA_W-1:0] load_v;

    // Halfword lane drops address bit 0; misaligned halves are not trapped.
    always_comb begin
        lane_a = aluR_q[LB-1:0];
        byte_v = mdata_q[{lane_a, 3'b000} +: 8];
        half_v = mdata_q[{lane_a[LB-1:1], 4'b0000} +: 16];
        case (ld_size_q)
            2'b01:   load_v = ld_uns_q ? {{(DATA_W-16){1'b0}}, half_v}
                                       : {{(DATA_W-16){half_v[15]}}, half_v};
            2'b10:   load_v = ld_uns_q ? {{(DATA_W-8){1'b0}}, byte_v}
                                       : {{(DATA_W-8){byte_v[7]}}, byte_v};
            default: load_v = mdata_q;
        endcase
    end

    assign wb_valid      = valid_q;
    assign wb_wreg       = wreg_q & valid_q & (destR_q != '0);
    assign wb_destR      = destR_q;
    assign wb_dest       = m2reg_q ? load_v : aluR_q;
    assign WB_ins_type   = type_q;
    assign WB_ins_number = number_q;
    assign wb_retire_cnt = cnt_q;

endmodule

// File: tb/tb_wb_stage_p.sv
// Bench for wb_stage_p: scoreboarded 32-bit instance plus a 64-bit instance
// with a 4-bit retire counter for wrap and wide-lane loads.
module tb_wb_stage_p;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 32-bit instance signals
    logic        m_valid = 0, m_stall = 0, m_flush = 0, m_wreg = 0, m_m2reg = 0, m_uns = 0;
    logic [4:0]  m_destR = 0;
    logic [31:0] m_alu = 0, m_md = 0;
    logic [1:0]  m_size = 0;
    logic [3:0]  m_typ = 0, m_num = 0;
    logic        o_valid, o_wreg;
    logic [4:0]  o_destR;
    logic [31:0] o_dest, o_cnt;
    logic [3:0]  o_typ, o_num;

    // 64-bit instance signals
    logic        w_valid = 0, w_m2reg = 0, w_uns = 0;
    logic [63:0] w_alu = 0, w_md = 0;
    logic [1:0]  w_size = 0;
    logic        wo_valid, wo_wreg;
    logic [4:0]  wo_destR;
    logic [63:0] wo_dest;
    logic [3:0]  wo_typ, wo_num, wo_cnt;

    wb_stage_p u_dut (
        .clk(clk), .rst(rst),
        .mem_valid(m_valid), .mem_stall(m_stall), .mem_flush(m_flush),
        .mem_destR(m_destR), .mem_aluR(m_alu), .mem_mdata(m_md),
        .mem_wreg(m_wreg), .mem_m2reg(m_m2reg), .mem_ld_size(m_size), .mem_ld_uns(m_uns),
        .MEM_ins_type(m_typ), .MEM_ins_number(m_num),
        .wb_valid(o_valid), .wb_wreg(o_wreg), .wb_destR(o_destR), .wb_dest(o_dest),
        .WB_ins_type(o_typ), .WB_ins_number(o_num), .wb_retire_cnt(o_cnt)
    );

    wb_stage_p #(.DATA_W(64), .CNT_W(4)) u_wide (
        .clk(clk), .rst(rst),
        .mem_valid(w_valid), .mem_stall(1'b0), .mem_flush(1'b0),
        .mem_destR(5'd1), .mem_aluR(w_alu), .mem_mdata(w_md),
        .mem_wreg(1'b1), .mem_m2reg(w_m2reg), .mem_ld_size(w_size), .mem_ld_uns(w_uns),
        .MEM_ins_type(4'd0), .MEM_ins_number(4'd0),
        .wb_valid(wo_valid), .wb_wreg(wo_wreg), .wb_destR(wo_destR), .wb_dest(wo_dest),
        .WB_ins_type(wo_typ), .WB_ins_number(wo_num), .wb_retire_cnt(wo_cnt)
    );

    int errors = 0;
    int checks = 0;

    function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endfunction

    typedef struct {
        logic        wreg;
        logic [4:0]  destR;
        logic [31:0] dest;
        logic [3:0]  typ;
        logic [3:0]  num;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_cnt = 0;
    logic        sb_en = 0;
    logic        adv = 0;

    // Monitor: an edge that advanced a valid instruction yields one output.
    always @(posedge clk) adv = sb_en && !rst && m_valid && !m_stall && !m_flush;

    always @(negedge clk) begin
        if (adv) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_valid", {63'd0, o_valid}, 64'd1);
                chk("sb_wreg",  {63'd0, o_wreg}, {63'd0, e.wreg});
                chk("sb_destR", {59'd0, o_destR}, {59'd0, e.destR});
                chk("sb_dest",  {32'd0, o_dest}, {32'd0, e.dest});
                chk("sb_type",  {60'd0, o_typ}, {60'd0, e.typ});
                chk("sb_num",   {60'd0, o_num}, {60'd0, e.num});
                chk("sb_cnt",   {32'd0, o_cnt}, {32'd0, e.cnt});
            end
        end
    end

    task automatic issue(input logic wreg, input logic m2reg, input logic [4:0] destR,
                         input logic [31:0] alu, input logic [31:0] md, input logic [1:0] size,
                         input logic uns, input logic [3:0] typ, input logic [3:0] num,
                         input logic [31:0] exp_dest, input logic exp_wreg);
        exp_t e;
        @(negedge clk);
        m_valid = 1; m_stall = 0; m_flush = 0;
        m_wreg = wreg; m_m2reg = m2reg; m_destR = destR; m_alu = alu; m_md = md;
        m_size = size; m_uns = uns; m_typ = typ; m_num = num;
        exp_cnt = exp_cnt + 1;
        e.wreg = exp_wreg; e.destR = destR; e.dest = exp_dest;
        e.typ = typ; e.num = num; e.cnt = exp_cnt;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        m_valid = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic wissue(input logic m2reg, input logic [1:0] size, input logic uns,
                          input logic [63:0] alu, input logic [63:0] md);
        w_valid = 1; w_m2reg = m2reg; w_size = size; w_uns = uns; w_alu = alu; w_md = md;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 0;

        // Asynchronous reset mid-cycle with live inputs.
        @(negedge clk);
        m_valid = 1; m_wreg = 1; m_destR = 5'd7; m_alu = 32'hDEAD; m_typ = 4'd3; m_num = 4'd9;
        @(posedge clk);
        #2;
        chk("pre_rst_dest", {32'd0, o_dest}, 64'hDEAD);
        chk("pre_rst_cnt", {32'd0, o_cnt}, 64'd1);
        rst = 1;
        #1;
        chk("rst_valid", {63'd0, o_valid}, 64'd0);
        chk("rst_wreg",  {63'd0, o_wreg}, 64'd0);
        chk("rst_destR", {59'd0, o_destR}, 64'd0);
        chk("rst_dest",  {32'd0, o_dest}, 64'd0);
        chk("rst_type",  {60'd0, o_typ}, 64'd0);
        chk("rst_num",   {60'd0, o_num}, 64'd0);
        chk("rst_cnt",   {32'd0, o_cnt}, 64'd0);
        @(negedge clk);
        rst = 0;
        m_valid = 0; m_wreg = 0; m_destR = 0; m_alu = 0; m_typ = 0; m_num = 0;
        sb_en = 1;

        // ALU writeback then loads from 0x80FF7F01.
        issue(1, 0, 5'd5,  32'h0000_1234, 32'h0,         2'b00, 0, 4'd1, 4'd1, 32'h0000_1234, 1);
        issue(1, 1, 5'd6,  32'h0000_1003, 32'h80FF_7F01, 2'b10, 0, 4'd2, 4'd2, 32'hFFFF_FF80, 1);
        issue(1, 1, 5'd7,  32'h0000_1001, 32'h80FF_7F01, 2'b10, 1, 4'd2, 4'd3, 32'h0000_007F, 1);
        issue(1, 1, 5'd8,  32'h0000_1002, 32'h80FF_7F01, 2'b01, 0, 4'd3, 4'd4, 32'hFFFF_80FF, 1);
        issue(1, 1, 5'd9,  32'h0000_1000, 32'h80FF_7F01, 2'b01, 1, 4'd3, 4'd5, 32'h0000_7F01, 1);
        issue(1, 1, 5'd10, 32'h0000_1003, 32'h80FF_7F01, 2'b01, 0, 4'd3, 4'd6, 32'hFFFF_80FF, 1);
        issue(1, 1, 5'd11, 32'h0000_1000, 32'h80FF_7F01, 2'b10, 0, 4'd2, 4'd7, 32'h0000_0001, 1);
        issue(1, 1, 5'd12, 32'h0000_1002, 32'h80FF_7F01, 2'b11, 0, 4'd4, 4'd8, 32'h80FF_7F01, 1);
        issue(1, 1, 5'd13, 32'h0000_1002, 32'h80FF_7F01, 2'b00, 1, 4'd4, 4'd9, 32'h80FF_7F01, 1);
        issue(0, 0, 5'd14, 32'hCAFE_0001, 32'h0,         2'b00, 0, 4'd5, 4'd10, 32'hCAFE_0001, 0);
        issue(1, 0, 5'd0,  32'h0000_0077, 32'h0,         2'b00, 0, 4'd6, 4'd11, 32'h0000_0077, 0);
        idle();
        idle();

        // Stall three cycles with changing inputs, then flush+stall together.
        issue(1, 0, 5'd3, 32'h0000_55AA, 32'h0, 2'b00, 0, 4'd1, 4'd2, 32'h0000_55AA, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("stall_dest", {32'd0, o_dest}, 64'h55AA);
                chk("stall_cnt",  {32'd0, o_cnt}, {32'd0, exp_cnt});
            end
            m_stall = 1; m_valid = 1; m_destR = 5'(i + 20); m_alu = $urandom;
            m_typ = 4'(i + 7); m_num = 4'(i + 12);
        end
        @(negedge clk);
        chk("stall_dest",  {32'd0, o_dest}, 64'h55AA);
        chk("stall_destR", {59'd0, o_destR}, 64'd3);
        chk("stall_wreg",  {63'd0, o_wreg}, 64'd1);
        chk("stall_type",  {60'd0, o_typ}, 64'd1);
        chk("stall_num",   {60'd0, o_num}, 64'd2);
        chk("stall_cnt",   {32'd0, o_cnt}, {32'd0, exp_cnt});
        m_flush = 1; m_stall = 1; m_valid = 1;
        @(negedge clk);
        chk("flush_valid", {63'd0, o_valid}, 64'd0);
        chk("flush_wreg",  {63'd0, o_wreg}, 64'd0);
        chk("flush_dest",  {32'd0, o_dest}, 64'd0);
        chk("flush_type",  {60'd0, o_typ}, 64'd0);
        chk("flush_cnt",   {32'd0, o_cnt}, {32'd0, exp_cnt});
        m_flush = 0; m_stall = 0; m_valid = 0;
        issue(1, 0, 5'd4, 32'h0000_0BEE, 32'h0, 2'b00, 0, 4'd8, 4'd8, 32'h0000_0BEE, 1);
        idle();
        idle();

        // 64-bit instance: 4-bit counter wrap and wide lanes.
        chk("w_rst_cnt", {60'd0, wo_cnt}, 64'd0);
        for (int i = 1; i <= 16; i++) begin
            wissue(0, 2'b00, 0, 64'(i), 64'h0);
            if (i == 15) chk("w_cnt15", {60'd0, wo_cnt}, 64'd15);
        end
        chk("w_cnt_wrap0", {60'd0, wo_cnt}, 64'd0);
        wissue(1, 2'b10, 1, 64'h7, 64'hAB00_0000_0000_0000);
        chk("w_byte7_uns", wo_dest, 64'h0000_0000_0000_00AB);
        chk("w_cnt17",     {60'd0, wo_cnt}, 64'd1);
        wissue(1, 2'b10, 0, 64'h7, 64'hAB00_0000_0000_0000);
        chk("w_byte7_sgn", wo_dest, 64'hFFFF_FFFF_FFFF_FFAB);
        wissue(1, 2'b01, 1, 64'h7, 64'hAB00_0000_0000_0000);
        chk("w_half3_uns", wo_dest, 64'h0000_0000_0000_AB00);
        wissue(1, 2'b01, 0, 64'h6, 64'hAB00_0000_0000_0000);
        chk("w_half3_sgn", wo_dest, 64'hFFFF_FFFF_FFFF_AB00);
        wissue(1, 2'b10, 1, 64'h4, 64'h0123_4567_89AB_CDEF);
        chk("w_byte4_uns", wo_dest, 64'h0000_0000_0000_0067);
        wissue(1, 2'b00, 0, 64'h4, 64'h0123_4567_89AB_CDEF);
        chk("w_word64",    wo_dest, 64'h0123_4567_89AB_CDEF);
        chk("w_cnt",       {60'd0, wo_cnt}, 64'd6);
        w_valid = 0;
        @(negedge clk);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("final_cnt", {32'd0, o_cnt}, {32'd0, exp_cnt});
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
